// File: rtl/player_motion_ctrl_if.sv
// Frame-rate handshake between the keyboard/collision side and the player motion sequencer.
// master drives keys, strobe and collision flags; slave returns the registered motion update.
interface player_motion_ctrl_if;
    logic        frame_tick;
    logic [31:0] keycode;
    logic        on_ground;
    logic        hit_ceiling;
    logic        hit_wall_left;
    logic        hit_wall_right;
    logic [9:0]  motion_x;
    logic [9:0]  motion_y;
    logic        motion_valid;
    logic [1:0]  state;
    logic        facing_left;

    modport master (
        output frame_tick, keycode, on_ground, hit_ceiling, hit_wall_left, hit_wall_right,
        input  motion_x, motion_y, motion_valid, state, facing_left
    );

    modport slave (
        input  frame_tick, keycode, on_ground, hit_ceiling, hit_wall_left, hit_wall_right,
        output motion_x, motion_y, motion_valid, state, facing_left
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// Per-frame player motion sequencer: key decode, GROUND/RISE/FALL jump FSM, horizontal ramp.
// Latency 1 Clk after frame_tick (motion_valid pulse); no backpressure, one update per frame.
module player_motion_ctrl #(
    parameter int         JUMP_V0   = 8,
    parameter int         MAX_HOLD  = 4,
    parameter int         GRAV_DIV  = 2,
    parameter int         MAX_FALL  = 6,
    parameter int         WALK_MAX  = 2,
    parameter logic [7:0] KEY_LEFT  = 8'h04,
    parameter logic [7:0] KEY_RIGHT = 8'h07,
    parameter logic [7:0] KEY_JUMP  = 8'h1A
) (
    input  logic Clk,
    input  logic Reset_n,
    player_motion_ctrl_if.slave bus
);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int GW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

    localparam logic [HW-1:0]     HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [GW-1:0]     GRAV_LAST = GW'(GRAV_DIV - 1);
    localparam logic signed [5:0] V0        = 6'(JUMP_V0);
    localparam logic signed [5:0] FALL_MAX  = 6'(MAX_FALL);
    localparam logic signed [5:0] WALK      = 6'(WALK_MAX);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } state_t;

    state_t             state_q;
    logic signed [5:0]  vx;
    logic signed [5:0]  vy;
    logic [HW-1:0]      hold_cnt;
    logic [GW-1:0]      grav_cnt;
    logic               jump_armed;
    logic               valid_q;
    logic               facing_q;

    logic               key_left;
    logic               key_right;
    logic               key_jump;
    logic signed [5:0]  vx_target;
    logic signed [5:0]  vx_next;
    logic signed [5:0]  vy_inc;
    logic               grav_wrap;
    logic [GW-1:0]      grav_next;

    always_comb begin
        key_left  = 1'b0;
        key_right = 1'b0;
        key_jump  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            key_left  = key_left  | (bus.keycode[8*i +: 8] == KEY_LEFT);
            key_right = key_right | (bus.keycode[8*i +: 8] == KEY_RIGHT);
            key_jump  = key_jump  | (bus.keycode[8*i +: 8] == KEY_JUMP);
        end
    end

    // Horizontal ramp: one px/frame step toward the target, then wall clamp on the new value.
    always_comb begin
        vx_target = 6'sd0;
        if (key_left && !key_right)
            vx_target = -WALK;
        else if (key_right && !key_left)
            vx_target = WALK;

        vx_next = vx;
        if (vx < vx_target)
            vx_next = vx + 6'sd1;
        else if (vx > vx_target)
            vx_next = vx - 6'sd1;

        if (bus.hit_wall_left && (vx_next < 6'sd0))
            vx_next = 6'sd0;
        if (bus.hit_wall_right && (vx_next > 6'sd0))
            vx_next = 6'sd0;
    end

    assign vy_inc    = vy + 6'sd1;
    assign grav_wrap = (grav_cnt == GRAV_LAST);
    assign grav_next = grav_wrap ? '0 : grav_cnt + 1'b1;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= GROUND;
            vx         <= '0;
            vy         <= '0;
            hold_cnt   <= '0;
            grav_cnt   <= '0;
            jump_armed <= 1'b0;
            valid_q    <= 1'b0;
            facing_q   <= 1'b0;
        end else begin
            valid_q <= bus.frame_tick;
            if (bus.frame_tick) begin
                vx <= vx_next;
                if (key_left ^ key_right)
                    facing_q <= key_left;
                if (!key_jump)
                    jump_armed <= 1'b1;

                case (state_q)
                    GROUND: begin
                        vy <= '0;
                        if (key_jump && jump_armed) begin
                            state_q    <= RISE;
                            vy         <= -V0;
                            hold_cnt   <= '0;
                            grav_cnt   <= '0;
                            jump_armed <= 1'b0;
                        end else if (!bus.on_ground) begin
                            state_q  <= FALL;
                            grav_cnt <= '0;
                        end
                    end
                    RISE: begin
                        if (bus.hit_ceiling) begin
                            state_q <= FALL;
                            vy      <= '0;
                        end else if (key_jump && (hold_cnt < HOLD_MAX)) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end else begin
                            // A release forfeits whatever hold time remained for this jump.
                            if (!key_jump)
                                hold_cnt <= HOLD_MAX;
                            grav_cnt <= grav_next;
                            if (grav_wrap) begin
                                vy <= vy_inc;
                                if (vy_inc == 6'sd0)
                                    state_q <= FALL;
                            end
                        end
                    end
                    FALL: begin
                        if (bus.on_ground) begin
                            state_q  <= GROUND;
                            vy       <= '0;
                            grav_cnt <= '0;
                        end else begin
                            grav_cnt <= grav_next;
                            if (grav_wrap && (vy < FALL_MAX))
                                vy <= vy_inc;
                        end
                    end
                    default: begin
                        state_q <= GROUND;
                        vy      <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.motion_x     = {{4{vx[5]}}, vx};
    assign bus.motion_y     = {{4{vy[5]}}, vy};
    assign bus.motion_valid = valid_q;
    assign bus.state        = state_q;
    assign bus.facing_left  = facing_q;
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl: each frame tick queues its expected motion update,
// and the negedge monitor pops and compares when motion_valid pulses.
module tb_player_motion_ctrl;
    logic Clk = 1'b0;
    logic Reset_n;

    always #5 Clk = ~Clk;

    player_motion_ctrl_if bus();

    player_motion_ctrl dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct {
        string      name;
        logic [9:0] mx;
        logic [9:0] my;
        logic [1:0] st;
        logic       face;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (bus.motion_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(bus.motion_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_mx"},    32'(bus.motion_x),    32'(e.mx));
                check({e.name, "_my"},    32'(bus.motion_y),    32'(e.my));
                check({e.name, "_state"}, 32'(bus.state),       32'(e.st));
                check({e.name, "_face"},  32'(bus.facing_left), 32'(e.face));
            end
        end
    end

    task automatic do_tick(input string name, input logic [31:0] kc,
                           input logic og, input logic ceil, input logic wl, input logic wr,
                           input int emx, input int emy, input int est, input logic ef);
        exp_t e;
        @(negedge Clk);
        bus.keycode        = kc;
        bus.on_ground      = og;
        bus.hit_ceiling    = ceil;
        bus.hit_wall_left  = wl;
        bus.hit_wall_right = wr;
        bus.frame_tick     = 1'b1;
        e.name = name;
        e.mx   = 10'(emx);
        e.my   = 10'(emy);
        e.st   = 2'(est);
        e.face = ef;
        exp_q.push_back(e);
        @(posedge Clk);
        #1 bus.frame_tick = 1'b0;
        @(negedge Clk);
        #1 check({name, "_consumed"}, 32'(exp_q.size()), 32'd0);
        @(negedge Clk);
        check({name, "_pulse_end"}, 32'(bus.motion_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_state"}, 32'(bus.state),        32'd0);
        check({name, "_mx"},    32'(bus.motion_x),     32'd0);
        check({name, "_my"},    32'(bus.motion_y),     32'd0);
        check({name, "_valid"}, 32'(bus.motion_valid), 32'd0);
        check({name, "_face"},  32'(bus.facing_left),  32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n            = 1'b0;
        bus.frame_tick     = 1'b1;
        bus.keycode        = 32'h0000_001A;
        bus.on_ground      = 1'b1;
        bus.hit_ceiling    = 1'b0;
        bus.hit_wall_left  = 1'b0;
        bus.hit_wall_right = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_reset_outputs("reset");
        Reset_n        = 1'b1;
        bus.frame_tick = 1'b0;
        bus.keycode    = '0;

        // Horizontal ramp, release decay, both-keys cancel, walls
        for (int i = 0; i < 4; i++)
            do_tick("walk_r", 32'h0000_0007, 1, 0, 0, 0, (i == 0) ? 1 : 2, 0, 0, 0);
        do_tick("rel_1",   32'h0, 1, 0, 0, 0, 1, 0, 0, 0);
        do_tick("rel_0",   32'h0, 1, 0, 0, 0, 0, 0, 0, 0);
        do_tick("r_again", 32'h0700_0000, 1, 0, 0, 0, 1, 0, 0, 0);
        do_tick("r_two",   32'h0700_0000, 1, 0, 0, 0, 2, 0, 0, 0);
        do_tick("both_1",  32'h0000_0704, 1, 0, 0, 0, 1, 0, 0, 0);
        do_tick("both_0",  32'h0000_0704, 1, 0, 0, 0, 0, 0, 0, 0);
        do_tick("left_1",  32'h0000_0400, 1, 0, 0, 0, -1, 0, 0, 1);
        do_tick("left_2",  32'h0004_0000, 1, 0, 0, 0, -2, 0, 0, 1);
        do_tick("wall_l",  32'h0000_0004, 1, 0, 1, 0, 0, 0, 0, 1);
        do_tick("left_3",  32'h0000_0004, 1, 0, 0, 0, -1, 0, 0, 1);
        do_tick("right_0", 32'h0000_0007, 1, 0, 0, 0, 0, 0, 0, 0);
        do_tick("wall_r",  32'h0000_0007, 1, 0, 0, 1, 0, 0, 0, 0);
        do_tick("idle",    32'h0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Full held jump: launch, hold, gravity ramp, apex, saturated fall
        do_tick("launch", 32'h001A_0000, 1, 0, 0, 0, 0, -8, 1, 0);
        for (int i = 0; i < 4; i++)
            do_tick("hold", 32'h0000_001A, 1, 0, 0, 0, 0, -8, 1, 0);
        for (int j = 1; j <= 15; j++)
            do_tick("rise_grav", 32'h0000_001A, 1, 0, 0, 0, 0, -8 + (j >> 1), 1, 0);
        do_tick("apex", 32'h0000_001A, 1, 0, 0, 0, 0, 0, 2, 0);
        for (int k = 1; k <= 16; k++)
            do_tick("fall", 32'h0000_001A, 0, 0, 0, 0, 0, ((k >> 1) > 6) ? 6 : (k >> 1), 2, 0);

        // Landing with jump still held must not relaunch until a released tick
        do_tick("land",       32'h0000_001A, 1, 0, 0, 0, 0, 0, 0, 0);
        do_tick("no_relaunch", 32'h0000_001A, 1, 0, 0, 0, 0, 0, 0, 0);
        do_tick("rearm",      32'h0, 1, 0, 0, 0, 0, 0, 0, 0);
        do_tick("relaunch",   32'h0000_001A, 1, 0, 0, 0, 0, -8, 1, 0);

        // Ceiling beats on_ground in RISE; ceiling ignored in FALL
        do_tick("ceiling",    32'h0000_001A, 1, 1, 0, 0, 0, 0, 2, 0);
        do_tick("ceil_fall0", 32'h0, 0, 1, 0, 0, 0, 0, 2, 0);
        do_tick("ceil_fall1", 32'h0, 0, 1, 0, 0, 0, 1, 2, 0);
        do_tick("ceil_land",  32'h0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Walk off an edge
        do_tick("edge", 32'h0, 0, 0, 0, 0, 0, 0, 2, 0);
        do_tick("edge_f1", 32'h0, 0, 0, 0, 0, 0, 0, 2, 0);
        do_tick("edge_f2", 32'h0, 0, 0, 0, 0, 0, 1, 2, 0);
        do_tick("edge_f3", 32'h0, 0, 0, 0, 0, 0, 1, 2, 0);
        do_tick("edge_f4", 32'h0, 0, 0, 0, 0, 0, 2, 2, 0);
        do_tick("edge_land", 32'h0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a jump
        do_tick("pre_left",   32'h0000_0004, 1, 0, 0, 0, -1, 0, 0, 1);
        do_tick("run_launch", 32'h0000_041A, 1, 0, 0, 0, -2, -8, 1, 1);
        @(negedge Clk);
        Reset_n        = 1'b0;
        bus.frame_tick = 1'b1;
        bus.keycode    = 32'h0000_001A;
        @(posedge Clk);
        @(negedge Clk);
        check_reset_outputs("mid_reset");
        Reset_n        = 1'b1;
        bus.frame_tick = 1'b0;

        do_tick("post_rst_unarmed", 32'h0000_001A, 1, 0, 0, 0, 0, 0, 0, 0);
        do_tick("post_rst_arm",     32'h0, 1, 0, 0, 0, 0, 0, 0, 0);
        do_tick("post_rst_jump",    32'h0000_001A, 1, 0, 0, 0, 0, -8, 1, 0);

        repeat (3) @(negedge Clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
